// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the IF/ID/EX hazard controller: RV32I opcodes,
// FSM state encoding and the register-usage decode helpers.
package pipe_hazard_ctrl_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BRA   = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_FLUSH   = 2'b01,
    ST_MEMWAIT = 2'b10
  } state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      OP_JALR, OP_LOAD, OP_ALUI, OP_BRA, OP_STORE, OP_OP: uses_rs1 = 1'b1;
      OP_LUI, OP_AUIPC, OP_JAL:                            uses_rs1 = 1'b0;
      default:                                             uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OP_BRA, OP_STORE, OP_OP: uses_rs2 = 1'b1;
      default:                 uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_reg_hazard_cmp.sv
// Matches one destination register against the source registers actually
// read by the decode-stage instruction; x0 never matches.
module reg_hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic [4:0] i_dst,
  input  logic       i_en,
  output logic       o_hit_rs1,
  output logic       o_hit_rs2
);

  logic w_dst_live;

  assign w_dst_live = i_en && (i_dst != 5'd0);
  assign o_hit_rs1  = w_dst_live && uses_rs1(i_opcode) && (i_dst == i_rs1);
  assign o_hit_rs2  = w_dst_live && uses_rs2(i_opcode) && (i_dst == i_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the IF/ID/EX front end: branch flush, data-memory
// freeze and load-use bubble in one FSM, plus the WB-to-decode bypass selects.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC   = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instr,
  input  logic [4:0]  ex_wreg,
  input  logic        ex_memread,
  input  logic [4:0]  wb_wreg,
  input  logic        wb_regwrite,
  input  logic        branch_taken,
  input  logic        dmem_busy,
  output logic        pc_keep,
  output logic        if_keep,
  output logic        if_flush,
  output logic        keep,
  output logic        nop,
  output logic [1:0]  ID_EX_write,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  localparam logic [7:0] FLUSH_INIT = 8'(FLUSH_CYC);
  localparam logic [7:0] FLUSH_RUN  = 8'(FLUSH_CYC - 1);
  localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);

  state_e      r_state, w_state_nxt;
  logic [7:0]  r_fcnt, w_fcnt_nxt;
  logic [7:0]  r_wcnt, w_wcnt_nxt;
  logic        r_pend_br, w_pend_nxt;
  logic        r_mem_err, w_mem_err_nxt;
  logic [15:0] r_stall_cnt;

  logic w_ex_hit1, w_ex_hit2, w_wb_hit1, w_wb_hit2;
  logic w_ldu, w_pend_any;
  logic w_pc_keep, w_if_keep, w_if_flush, w_keep, w_nop;
  logic w_unused_instr;

  assign w_unused_instr = ^{id_instr[31:25], id_instr[14:7]};

  reg_hazard_cmp u_ex_cmp (
    .i_opcode  (id_instr[6:0]),
    .i_rs1     (id_instr[19:15]),
    .i_rs2     (id_instr[24:20]),
    .i_dst     (ex_wreg),
    .i_en      (ex_memread),
    .o_hit_rs1 (w_ex_hit1),
    .o_hit_rs2 (w_ex_hit2)
  );

  reg_hazard_cmp u_wb_cmp (
    .i_opcode  (id_instr[6:0]),
    .i_rs1     (id_instr[19:15]),
    .i_rs2     (id_instr[24:20]),
    .i_dst     (wb_wreg),
    .i_en      (wb_regwrite),
    .o_hit_rs1 (w_wb_hit1),
    .o_hit_rs2 (w_wb_hit2)
  );

  assign w_ldu      = w_ex_hit1 || w_ex_hit2;
  assign w_pend_any = r_pend_br || branch_taken;

  always_comb begin
    w_state_nxt   = r_state;
    w_fcnt_nxt    = r_fcnt;
    w_wcnt_nxt    = r_wcnt;
    w_pend_nxt    = r_pend_br;
    w_mem_err_nxt = r_mem_err;
    w_pc_keep     = 1'b0;
    w_if_keep     = 1'b0;
    w_if_flush    = 1'b0;
    w_keep        = 1'b0;
    w_nop         = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (branch_taken) begin
          w_if_flush = 1'b1;
          w_nop      = 1'b1;
          if (FLUSH_CYC > 1) begin
            w_state_nxt = ST_FLUSH;
            w_fcnt_nxt  = FLUSH_RUN;
          end
        end else if (dmem_busy) begin
          w_pc_keep   = 1'b1;
          w_if_keep   = 1'b1;
          w_keep      = 1'b1;
          w_state_nxt = ST_MEMWAIT;
          w_wcnt_nxt  = 8'd1;
          w_pend_nxt  = 1'b0;
        end else if (w_ldu) begin
          w_pc_keep = 1'b1;
          w_if_keep = 1'b1;
          w_nop     = 1'b1;
        end
      end
      ST_FLUSH: begin
        w_if_flush = 1'b1;
        w_nop      = 1'b1;
        w_fcnt_nxt = r_fcnt - 8'd1;
        if (r_fcnt <= 8'd1) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_MEMWAIT: begin
        // A branch resolved during the freeze is replayed as a full flush on exit.
        if (dmem_busy) begin
          w_pc_keep = 1'b1;
          w_if_keep = 1'b1;
          w_keep    = 1'b1;
        end
        if (dmem_busy && (r_wcnt < TIMEOUT)) begin
          w_wcnt_nxt = r_wcnt + 8'd1;
          w_pend_nxt = w_pend_any;
        end else begin
          w_wcnt_nxt = 8'd0;
          w_pend_nxt = 1'b0;
          if (dmem_busy) begin
            w_mem_err_nxt = 1'b1;
          end
          if (w_pend_any) begin
            w_state_nxt = ST_FLUSH;
            w_fcnt_nxt  = FLUSH_INIT;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_fcnt      <= 8'd0;
      r_wcnt      <= 8'd0;
      r_pend_br   <= 1'b0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_fcnt    <= w_fcnt_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_pend_br <= w_pend_nxt;
      r_mem_err <= w_mem_err_nxt;
      if (w_pc_keep && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  // Reset forces every output low even though the controls are combinational.
  assign pc_keep     = rst && w_pc_keep;
  assign if_keep     = rst && w_if_keep;
  assign if_flush    = rst && w_if_flush;
  assign keep        = rst && w_keep;
  assign nop         = rst && w_nop;
  assign ID_EX_write = rst ? {w_wb_hit1, w_wb_hit2} : 2'b00;
  assign mem_err     = r_mem_err;
  assign stall_cnt   = r_stall_cnt;

  a_nop_keep_excl: assert property (@(posedge clk) disable iff (!rst) !(nop && keep));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl: a bubble/freeze-budget model is compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  localparam int FC = 2;
  localparam int TO = 6;

  localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111, O_JAL = 7'b1101111;
  localparam logic [6:0] O_JALR = 7'b1100111, O_BRA = 7'b1100011, O_LOAD = 7'b0000011;
  localparam logic [6:0] O_STORE = 7'b0100011, O_ALUI = 7'b0010011, O_OP = 7'b0110011;
  localparam logic [6:0] O_BAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic [4:0]  ex_wreg, wb_wreg;
  logic        ex_memread, wb_regwrite, branch_taken, dmem_busy;
  logic        pc_keep, if_keep, if_flush, keep, nop, mem_err;
  logic [1:0]  ID_EX_write;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYC(FC), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .ex_wreg(ex_wreg),
    .ex_memread(ex_memread), .wb_wreg(wb_wreg), .wb_regwrite(wb_regwrite),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy), .pc_keep(pc_keep),
    .if_keep(if_keep), .if_flush(if_flush), .keep(keep), .nop(nop),
    .ID_EX_write(ID_EX_write), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: bubbles still owed after a branch, freeze length so far, pending branch.
  int m_flush_left, m_wcnt, m_stall;
  bit m_wait, m_pend, m_err;

  logic [4:0] e_ctrl;  // {pc_keep, if_keep, if_flush, keep, nop}
  logic [1:0] e_byp;
  logic       e_ldu, e_u1, e_u2;
  logic [6:0] e_op;
  logic [4:0] e_rs1, e_rs2;

  always_comb begin
    e_op  = id_instr[6:0];
    e_rs1 = id_instr[19:15];
    e_rs2 = id_instr[24:20];
    e_u1  = (e_op == O_JALR) || (e_op == O_LOAD) || (e_op == O_ALUI) ||
            (e_op == O_BRA) || (e_op == O_STORE) || (e_op == O_OP);
    e_u2  = (e_op == O_BRA) || (e_op == O_STORE) || (e_op == O_OP);
    e_ldu = ex_memread && (ex_wreg != 0) &&
            ((e_u1 && ex_wreg == e_rs1) || (e_u2 && ex_wreg == e_rs2));
    e_byp = 2'b00;
    e_ctrl = 5'b00000;
    if (rst === 1'b1) begin
      e_byp[1] = wb_regwrite && (wb_wreg != 0) && (wb_wreg == e_rs1) && e_u1;
      e_byp[0] = wb_regwrite && (wb_wreg != 0) && (wb_wreg == e_rs2) && e_u2;
      if (m_flush_left > 0)  e_ctrl = 5'b00101;
      else if (m_wait)       e_ctrl = dmem_busy ? 5'b11010 : 5'b00000;
      else if (branch_taken) e_ctrl = 5'b00101;
      else if (dmem_busy)    e_ctrl = 5'b11010;
      else if (e_ldu)        e_ctrl = 5'b11001;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_flush_left <= 0;
      m_wcnt       <= 0;
      m_stall      <= 0;
      m_wait       <= 1'b0;
      m_pend       <= 1'b0;
      m_err        <= 1'b0;
    end else begin
      if (e_ctrl[4] && m_stall < 65535) m_stall <= m_stall + 1;
      if (m_flush_left > 0) begin
        m_flush_left <= m_flush_left - 1;
      end else if (m_wait) begin
        if (dmem_busy && m_wcnt < TO) begin
          m_wcnt <= m_wcnt + 1;
          m_pend <= m_pend | branch_taken;
        end else begin
          m_wait <= 1'b0;
          m_pend <= 1'b0;
          if (dmem_busy) m_err <= 1'b1;
          if (m_pend || branch_taken) m_flush_left <= FC;
        end
      end else if (branch_taken) begin
        m_flush_left <= FC - 1;
      end else if (dmem_busy) begin
        m_wait <= 1'b1;
        m_wcnt <= 1;
        m_pend <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_ctrl", {27'd0, pc_keep, if_keep, if_flush, keep, nop}, {27'd0, e_ctrl});
    chk("model_bypass", {30'd0, ID_EX_write}, {30'd0, e_byp});
    chk("model_mem_err", {31'd0, mem_err}, {31'd0, m_err});
    chk("model_stall_cnt", {16'd0, stall_cnt}, m_stall);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [4:0] rd, input logic [6:0] op);
    return {7'd0, rs2, rs1, 3'b010, rd, op};
  endfunction

  logic [6:0] op_tbl [10];
  int burst_left;

  initial begin
    op_tbl = '{O_LUI, O_AUIPC, O_JAL, O_JALR, O_BRA, O_LOAD, O_STORE, O_ALUI, O_OP, O_BAD};
    rst = 1'b0;
    id_instr = r_type(5'd3, 5'd3, 5'd0, O_STORE);
    ex_wreg = 5'd3; ex_memread = 1'b1;
    wb_wreg = 5'd3; wb_regwrite = 1'b1;
    branch_taken = 1'b1; dmem_busy = 1'b1;
    #3;
    chk("reset_ctrl", {27'd0, pc_keep, if_keep, if_flush, keep, nop}, 32'd0);
    chk("reset_bypass", {30'd0, ID_EX_write}, 32'd0);
    chk("reset_stall", {16'd0, stall_cnt}, 32'd0);
    branch_taken = 1'b0; dmem_busy = 1'b0; ex_memread = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // WB x3 against sw x3,0(x3)
    @(negedge clk);
    chk("bypass_sw_x3", {30'd0, ID_EX_write}, 32'd3);
    step();
    wb_wreg = 5'd0; id_instr = r_type(5'd0, 5'd0, 5'd1, O_OP);
    @(negedge clk);
    chk("bypass_x0", {30'd0, ID_EX_write}, 32'd0);
    step();
    wb_wreg = 5'd3; id_instr = r_type(5'd3, 5'd3, 5'd3, O_LUI);
    @(negedge clk);
    chk("bypass_lui", {30'd0, ID_EX_write}, 32'd0);

    // load-use: lw x5 in EX, add x6,x5,x7 in ID
    step();
    wb_regwrite = 1'b0;
    id_instr = r_type(5'd7, 5'd5, 5'd6, O_OP);
    ex_wreg = 5'd5; ex_memread = 1'b1;
    @(negedge clk);
    chk("ldu_bubble", {27'd0, pc_keep, if_keep, if_flush, keep, nop}, 32'b11001);
    step();
    ex_memread = 1'b0; ex_wreg = 5'd6;
    @(negedge clk);
    chk("ldu_after", {27'd0, pc_keep, if_keep, if_flush, keep, nop}, 32'd0);
    chk("ldu_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // taken branch; a second one during FLUSH is ignored
    step(); branch_taken = 1'b1;
    @(negedge clk);
    chk("br_cycle1", {27'd0, pc_keep, if_keep, if_flush, keep, nop}, 32'b00101);
    step();
    @(negedge clk);
    chk("br_cycle2", {27'd0, pc_keep, if_keep, if_flush, keep, nop}, 32'b00101);
    step(); branch_taken = 1'b0;
    @(negedge clk);
    chk("br_done", {27'd0, pc_keep, if_keep, if_flush, keep, nop}, 32'd0);

    // 5-cycle memory wait with a branch in cycle 3
    for (int i = 1; i <= 5; i++) begin
      step(); dmem_busy = 1'b1; branch_taken = (i == 3);
      @(negedge clk);
      chk("memwait_keep", {27'd0, pc_keep, if_keep, if_flush, keep, nop}, 32'b11010);
    end
    step(); dmem_busy = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    chk("memwait_release", {27'd0, pc_keep, if_keep, if_flush, keep, nop}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      chk("memwait_flush", {27'd0, pc_keep, if_keep, if_flush, keep, nop}, 32'b00101);
    end
    step();
    @(negedge clk);
    chk("memwait_run", {27'd0, pc_keep, if_keep, if_flush, keep, nop}, 32'd0);
    chk("memwait_stall", {16'd0, stall_cnt}, 32'd6);

    // async reset mid-MEMWAIT with stall_cnt at 9
    for (int i = 0; i < 4; i++) begin
      step(); dmem_busy = 1'b1;
    end
    @(negedge clk);
    chk("pre_reset_stall", {16'd0, stall_cnt}, 32'd9);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ctrl", {27'd0, pc_keep, if_keep, if_flush, keep, nop}, 32'd0);
    chk("async_rst_stall", {16'd0, stall_cnt}, 32'd0);
    step(); dmem_busy = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("after_rst_run", {27'd0, pc_keep, if_keep, if_flush, keep, nop}, 32'd0);

    // stuck memory: mem_err after the TO-th MEMWAIT cycle (RUN cycle + TO cycles)
    for (int i = 1; i <= TO + 1; i++) begin
      step(); dmem_busy = 1'b1;
      @(negedge clk);
      chk("timeout_pre", {31'd0, mem_err}, 32'd0);
    end
    step();
    @(negedge clk);
    chk("timeout_err", {31'd0, mem_err}, 32'd1);
    step(); dmem_busy = 1'b0;
    step();
    @(negedge clk);
    chk("timeout_sticky", {31'd0, mem_err}, 32'd1);

    // randomized traffic
    burst_left = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      id_instr = {7'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'b010,
                  5'($urandom_range(0, 7)), op_tbl[$urandom_range(0, 9)]};
      ex_wreg      = 5'($urandom_range(0, 7));
      ex_memread   = ($urandom_range(0, 3) == 0);
      wb_wreg      = 5'($urandom_range(0, 7));
      wb_regwrite  = ($urandom_range(0, 1) == 1);
      branch_taken = ($urandom_range(0, 11) == 0);
      if (burst_left > 0) begin
        dmem_busy = 1'b1;
        burst_left--;
      end else if ($urandom_range(0, 9) == 0) begin
        dmem_busy = 1'b1;
        burst_left = $urandom_range(0, 8);
      end else begin
        dmem_busy = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b0;
        #4 rst = 1'b1;
      end
    end
    step();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
